// File: rtl/shift_add_multiplier.sv
// Sequential unsigned add-shift multiplier with ADD/SHIFT micro-ops exported on mult_op.
// Optional MULT_SKIP_ZERO_ADD_EN: bypass the ADD step for multiplier bits that are zero.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         mult_op
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_ADD   = 2'd1;
    localparam logic [1:0] OP_SHIFT = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] q_shift;
    logic [CW-1:0]    count_next;

    // {C,A,Q} shifted right by one; C refills with zero.
    assign sum        = {1'b0, a} + {1'b0, m};
    assign a_shift    = {c, a[WIDTH-1:1]};
    assign q_shift    = {a[0], q[WIDTH-1:1]};
    assign count_next = count + CW'(1);

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples pre-edge values; outputs are registered alongside the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            product <= '0;
            mult_op <= OP_NONE;
            c       <= 1'b0;
            a       <= '0;
            q       <= '0;
            m       <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= multiplicand;
                        q     <= multiplier;
                        a     <= '0;
                        c     <= 1'b0;
                        count <= '0;
                        ready <= 1'b0;
`ifdef MULT_SKIP_ZERO_ADD_EN
                        if (multiplier[0]) begin
                            state   <= ADD;
                            mult_op <= OP_ADD;
                        end else begin
                            state   <= SHIFT;
                            mult_op <= OP_SHIFT;
                        end
`else
                        state   <= ADD;
                        mult_op <= OP_ADD;
`endif
                    end
                end

                ADD: begin
                    if (q[0]) begin
                        {c, a} <= sum;
                    end else begin
                        c <= 1'b0;
                    end
                    state   <= SHIFT;
                    mult_op <= OP_SHIFT;
                end

                SHIFT: begin
                    a     <= a_shift;
                    q     <= q_shift;
                    c     <= 1'b0;
                    count <= count_next;
                    if (count_next == LAST) begin
                        state   <= DONE;
                        mult_op <= OP_NONE;
                        done    <= 1'b1;
                        product <= {a_shift, q_shift};
                    end else begin
`ifdef MULT_SKIP_ZERO_ADD_EN
                        if (q_shift[0]) begin
                            state   <= ADD;
                            mult_op <= OP_ADD;
                        end else begin
                            state   <= SHIFT;
                            mult_op <= OP_SHIFT;
                        end
`else
                        state   <= ADD;
                        mult_op <= OP_ADD;
`endif
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    mult_op <= OP_NONE;
                end

                default: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    mult_op <= OP_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: per-cycle schedule model plus directed vectors.
// Honours MULT_SKIP_ZERO_ADD_EN when the design is built with it.
module tb_shift_add_multiplier;

    localparam int WIDTH = 8;
`ifdef MULT_SKIP_ZERO_ADD_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // Model schedule entries
    localparam int M_IDLE  = 0;
    localparam int M_ADD   = 1;
    localparam int M_SHIFT = 2;
    localparam int M_DONE  = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   multiplicand = '0;
    logic [WIDTH-1:0]   multiplier = '0;
    logic               ready;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic [1:0]         mult_op;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    int          m_cur = M_IDLE;
    int          m_ops[$];
    logic [31:0] m_prod = '0;
    logic [31:0] m_pend = '0;

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .done         (done),
        .product      (product),
        .mult_op      (mult_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [WIDTH-1:0] b);
        return SKIP ? (WIDTH + $countones(b) + 1) : (2 * WIDTH + 1);
    endfunction

    // Model: on accept, lay out the micro-op schedule for every multiplier bit, then DONE.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_ops.delete();
                m_cur  = M_IDLE;
                m_prod = '0;
            end else if (m_cur == M_IDLE) begin
                if (start) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (!SKIP || multiplier[i]) m_ops.push_back(M_ADD);
                        m_ops.push_back(M_SHIFT);
                    end
                    m_ops.push_back(M_DONE);
                    m_pend = 32'(multiplicand) * 32'(multiplier);
                    m_cur  = m_ops.pop_front();
                end
            end else if (m_ops.size() > 0) begin
                m_cur = m_ops.pop_front();
                if (m_cur == M_DONE) m_prod = m_pend;
            end else begin
                m_cur = M_IDLE;
            end
        end
    end

    // Compare process: every cycle, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("model_ready", 32'(ready), 32'(m_cur == M_IDLE));
                check("model_done", 32'(done), 32'(m_cur == M_DONE));
                check("model_mult_op", 32'(mult_op),
                      (m_cur == M_ADD) ? 32'd1 : (m_cur == M_SHIFT) ? 32'd2 : 32'd0);
                check("model_product", 32'(product), m_prod);
            end
        end
    end

    // One operation from IDLE; optional poke of start with 0x10*0x10 in cycle 'poke'.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int poke,
                         output int lat, output logic [31:0] prod, output int adds,
                         output int busy_ready);
        @(negedge clk);
        #1;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        lat = 0;
        adds = 0;
        busy_ready = 0;
        prod = '0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) begin
                prod = 32'(product);
                break;
            end
            if (mult_op == 2'd1) adds++;
            if (ready) busy_ready++;
            if (lat == 1) begin
                #1;
                start        = 1'b0;
                multiplicand = WIDTH'($urandom);
                multiplier   = WIDTH'($urandom);
            end
            if (lat == poke) begin
                #1;
                start        = 1'b1;
                multiplicand = 8'h10;
                multiplier   = 8'h10;
            end else if (poke > 0 && lat == poke + 1) begin
                #1;
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(ready), 32'd1);
    endtask

    initial begin
        int          lat;
        int          adds;
        int          busy;
        int          gap;
        int          pulses;
        logic [31:0] prod;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        repeat (2) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_mult_op", 32'(mult_op), 32'd0);
        #1 reset = 1'b0;
        cmp_en = 1'b1;

        // Max operands
        do_op(8'hFF, 8'hFF, 0, lat, prod, adds, busy);
        check("ff_product", prod, 32'hFE01);
        check("ff_latency", 32'(lat), 32'd17);
        check("ff_adds", 32'(adds), 32'd8);
        check("ff_ready_busy", 32'(busy), 32'd0);

        // Zero operands
        do_op(8'h00, 8'hA5, 0, lat, prod, adds, busy);
        check("zero_a_product", prod, 32'h0000);
        check("zero_a_latency", 32'(lat), SKIP ? 32'd13 : 32'd17);
        do_op(8'h5A, 8'h00, 0, lat, prod, adds, busy);
        check("zero_b_product", prod, 32'h0000);
        check("zero_b_latency", 32'(lat), SKIP ? 32'd9 : 32'd17);
        check("zero_b_adds", 32'(adds), SKIP ? 32'd0 : 32'd8);

        // Start while busy is ignored
        do_op(8'h03, 8'h05, 4, lat, prod, adds, busy);
        check("busy_product", prod, 32'h000F);
        check("busy_latency", 32'(lat), 32'(exp_lat(8'h05)));
        check("busy_hold", 32'(product), 32'h000F);
        do_op(8'h10, 8'h10, 0, lat, prod, adds, busy);
        check("fresh_product", prod, 32'h0100);

        // Reset mid-operation
        @(negedge clk);
        #1;
        multiplicand = 8'h12;
        multiplier   = 8'h34;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_mult_op", 32'(mult_op), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        do_op(8'h12, 8'h34, 0, lat, prod, adds, busy);
        check("after_abort_product", prod, 32'h03A8);

        // Back-to-back with start held high
        @(negedge clk);
        #1;
        multiplicand = 8'h07;
        multiplier   = 8'h09;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        multiplicand = 8'hC8;
        multiplier   = 8'h02;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_product", 32'(product), 32'h003F);
        check("b2b_first_latency", 32'(lat), 32'(exp_lat(8'h09)));
        gap = 0;
        while (gap < 100) begin
            @(negedge clk);
            gap++;
            if (done) break;
            check("b2b_product_stable", 32'(product), 32'h003F);
        end
        #1 start = 1'b0;
        check("b2b_second_product", 32'(product), 32'h0190);
        check("b2b_gap", 32'(gap), 32'(1 + exp_lat(8'h02)));
        @(negedge clk);
        @(negedge clk);

        // Random sweep
        for (int k = 0; k < 1000; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            do_op(ra, rb, 0, lat, prod, adds, busy);
            check("rand_product", prod, 32'(ra) * 32'(rb));
            check("rand_latency", 32'(lat), 32'(exp_lat(rb)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential unsigned add-shift multiplier. It is the DUT end of the multiplier bench interface: the bench drives operands and start, and this block returns ready/done/product. Each operand bit is processed with an ADD step and a SHIFT step. The current micro-op is exported on mult_op so the bench can trace internal progress.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to begin a multiply; sampled only while ready=1
- multiplicand  input  WIDTH  unsigned operand M
- multiplier  input  WIDTH  unsigned operand Q
- ready  output  1  high only in IDLE; block accepts start
- done  output  1  one-cycle pulse, high only in DONE
- product  output  2*WIDTH  result register
- mult_op  output  2  current micro-op: 0=NONE, 1=ADD, 2=SHIFT

Behaviour:
- Reset (async, high): state=IDLE, ready=1, done=0, product=0, mult_op=NONE, internal A/Q/C/count=0. Reset mid-operation aborts with no done pulse; the next start is accepted normally.
- States: IDLE, ADD, SHIFT, DONE.
- Internal datapath: carry C (1b), accumulator A (WIDTH), Q (WIDTH), M latch (WIDTH), bit counter count (clog2(WIDTH+1) bits).
- IDLE:
  - On a clk edge with start=1: latch M=multiplicand, Q=multiplier; clear A, C and count; go to ADD.
  - start=0: stay in IDLE.
- ADD (mult_op=1):
  - If Q[0]=1: {C,A} = A + M, computed at WIDTH+1 bits.
  - Else: A unchanged, C=0.
  - Always go to SHIFT.
- SHIFT (mult_op=2):
  - {C,A,Q} logical right-shift by 1; C becomes 0.
  - count += 1.
  - If count reaches WIDTH, go to DONE; else go to ADD.
- DONE (mult_op=0):
  - done=1 for exactly this cycle, ready=0.
  - product was loaded with {A,Q} on the edge entering DONE.
  - Next state is IDLE.
- mult_op=0 in IDLE and DONE.
- product:
  - Changes only on entry to DONE (and on reset).
  - Holds its value through IDLE and through the whole next operation until that operation's DONE entry.
- Latency (no optional feature): accept edge, then 2*WIDTH cycles of ADD/SHIFT, then 1 DONE cycle. For WIDTH=8, done is high in the 17th cycle after the accept edge, and ready returns the cycle after.
- start while ready=0 (ADD, SHIFT or DONE) is ignored and not queued. Operand changes after the accept edge have no effect.
- start held high continuously: a new operation is accepted on each IDLE cycle, giving back-to-back operations with one IDLE cycle between them.
- Arithmetic is unsigned, with no overflow possible. product = multiplicand * multiplier exactly, for all 2^(2*WIDTH) operand pairs.

Optional Feature:
- Macro: MULT_SKIP_ZERO_ADD_EN
- Defined: from SHIFT (and from IDLE at accept), if the next Q[0]=0, the block bypasses ADD and performs SHIFT directly, so mult_op never shows ADD for a zero bit.
  - Latency = WIDTH + popcount(multiplier) ADD/SHIFT cycles, plus 1 DONE cycle.
  - Result is identical to the non-skip case.
- Undefined: every bit takes both an ADD and a SHIFT cycle, as described in Behaviour.

Test Plan:
- Max operands, WIDTH=8: reset, start with 0xFF*0xFF.
  - product=0xFE01 with done high exactly 17 cycles after accept; ready=0 throughout, then 1.
  - mult_op alternates 1,2 sixteen times.
- Zero operands: 0x00*0xA5 and 0x5A*0x00.
  - product=0x0000, done pulse exactly one cycle.
  - With MULT_SKIP_ZERO_ADD_EN: for 0x5A*0x00, done comes 9 cycles after accept and mult_op never equals 1.
- Start while busy: accept 0x03*0x05, then pulse start with 0x10*0x10 at cycle 4.
  - Pulse is ignored; product=0x000F; the second product appears only after a fresh start in IDLE.
- Reset mid-operation: accept 0x12*0x34, assert reset at cycle 7.
  - Immediately ready=1, done=0, product=0, mult_op=0; no done pulse follows.
  - Then 0x12*0x34 gives product=0x03A8.
- Back-to-back: start held high with operands changing each operation (0x07*0x09, 0xC8*0x02).
  - Products 0x003F then 0x0190.
  - Exactly one IDLE cycle between done pulses; product stable between them.
- Random sweep: 1000 random pairs checked against a*b.
  - Under MULT_SKIP_ZERO_ADD_EN, done latency must equal 8 + popcount(multiplier) + 1.
